// File: rtl/strided_window_gen_pkg.sv
// strided_window_pkg: FSM state type and shift-buffer sizing shared by the window generator.
package strided_window_pkg;
  typedef enum logic {FILL, RUN} state_t;
  function automatic int buffer_size(input int k, input int rs);
    return (k - 1) * rs + k;
  endfunction
endpackage

// File: rtl/strided_window_gen_if.sv
// strided_window_gen_if: pixel stream in, window stream out; max_out exists only with WINDOW_MAX_EN.
interface strided_window_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3
);
  logic [DATA_WIDTH-1:0] inputPixel;
  logic in_valid, in_ready, valid, out_ready, frame_done;
  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][DATA_WIDTH-1:0] window;
`ifdef WINDOW_MAX_EN
  logic [DATA_WIDTH-1:0] max_out;
  modport master (output inputPixel, in_valid, out_ready, input in_ready, window, valid, frame_done, max_out);
  modport slave (input inputPixel, in_valid, out_ready, output in_ready, window, valid, frame_done, max_out);
`else
  modport master (output inputPixel, in_valid, out_ready, input in_ready, window, valid, frame_done);
  modport slave (input inputPixel, in_valid, out_ready, output in_ready, window, valid, frame_done);
`endif
endinterface

// File: rtl/strided_window_gen_max_tree.sv
// window_max_tree: combinational unsigned maximum of N pixels, compiled only with WINDOW_MAX_EN.
`ifdef WINDOW_MAX_EN
module window_max_tree #(
  parameter int DATA_WIDTH = 8,
  parameter int N = 9
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] px_i,
  output logic [DATA_WIDTH-1:0]        max_o
);
  always_comb begin
    max_o = px_i[0];
    for (int i = 1; i < N; i++) max_o = px_i[i] > max_o ? px_i[i] : max_o;
  end
endmodule
`endif

// File: rtl/strided_window_gen.sv
// strided_window_gen: raster pixel stream to stride-aligned KxK windows with a one-entry output register.
// Optional WINDOW_MAX_EN adds a registered window maximum (max_out).
module strided_window_gen
  import strided_window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3,
  parameter int ROW_SIZE   = 5,
  parameter int COL_SIZE   = 5,
  parameter int STRIDE     = 1
) (
  input logic clk,
  input logic rst,
  strided_window_gen_if.slave s
);
  localparam int BS = buffer_size(KERNEL_DIM, ROW_SIZE);
  localparam int CW = $clog2(ROW_SIZE);
  localparam int RW = $clog2(COL_SIZE);
  localparam int KM = KERNEL_DIM - 1;
  logic [BS-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  state_t state_q;
  logic valid_q, fd_q, acc, load, col_end, row_end;
  assign s.in_ready   = !valid_q || s.out_ready;
  assign s.valid      = valid_q;
  assign s.window     = win_q;
  assign s.frame_done = fd_q;
  // buf_d[0] is the newest pixel, so a window tap sits (KM-r) rows and (KM-c) pixels back
  always_comb begin
    acc     = s.in_valid && s.in_ready;
    col_end = col_q == CW'(ROW_SIZE - 1);
    row_end = row_q == RW'(COL_SIZE - 1);
    buf_d   = acc ? {buf_q[BS-2:0], s.inputPixel} : buf_q;
    col_d   = !acc ? col_q : col_end ? '0 : col_q + 1'b1;
    row_d   = (!acc || !col_end) ? row_q : row_end ? '0 : row_q + 1'b1;
    load    = acc && state_q == RUN && int'(col_q) >= KM &&
              (int'(col_q) - KM) % STRIDE == 0 && (int'(row_q) - KM) % STRIDE == 0;
    win_d   = win_q;
    for (int r = 0; r < KERNEL_DIM; r++)
      for (int c = 0; c < KERNEL_DIM; c++)
        win_d[r][c] = load ? buf_d[(KM - r) * ROW_SIZE + KM - c] : win_q[r][c];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      buf_q   <= '0;
      win_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FILL;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      win_q   <= win_d;
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= !acc ? state_q :
                 state_q == FILL ? (int'(row_d) >= KM ? RUN : FILL) :
                 (row_end && col_end ? FILL : RUN);
      valid_q <= load || (valid_q && !s.out_ready);
      fd_q    <= acc && col_end && row_end;
    end
`ifdef WINDOW_MAX_EN
  logic [DATA_WIDTH-1:0] max_d, max_q;
  window_max_tree #(.DATA_WIDTH(DATA_WIDTH), .N(KERNEL_DIM * KERNEL_DIM)) u_max (
    .px_i (win_d),
    .max_o(max_d)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) max_q <= '0;
    else     max_q <= load ? max_d : max_q;
  assign s.max_out = max_q;
`endif
endmodule

// File: tb/tb_strided_window_gen.sv
// tb_strided_window_gen: directed 5x5 ramp frames into a stride-1 and a stride-2 generator.
module tb_strided_window_gen;
  typedef logic [2:0][2:0][7:0] win_t;
  typedef struct {win_t w; int acc; logic [7:0] mx;} cap_t;
  typedef struct {int centre; int acc; int mx;} vec_t;
  logic clk = 1'b0, rst = 1'b1, vld = 1'b0, or_a = 1'b1;
  logic [7:0] pix = '0, mxa, mxb;
  int passed = 0, total = 0, cnt = 0, fd_a = 0, fd_b = 0;
  cap_t qa[$], qb[$];
  vec_t t1[9], t2[4];
  always #5 clk = ~clk;
  strided_window_gen_if #(.DATA_WIDTH(8), .KERNEL_DIM(3)) ifa ();
  strided_window_gen_if #(.DATA_WIDTH(8), .KERNEL_DIM(3)) ifb ();
  assign ifa.inputPixel = pix;
  assign ifa.in_valid   = vld;
  assign ifa.out_ready  = or_a;
  assign ifb.inputPixel = pix;
  assign ifb.in_valid   = vld && ifa.in_ready;
  assign ifb.out_ready  = 1'b1;
`ifdef WINDOW_MAX_EN
  assign mxa = ifa.max_out;
  assign mxb = ifb.max_out;
`else
  assign mxa = '0;
  assign mxb = '0;
`endif
  strided_window_gen #(.DATA_WIDTH(8), .KERNEL_DIM(3), .ROW_SIZE(5), .COL_SIZE(5), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .s(ifa.slave));
  strided_window_gen #(.DATA_WIDTH(8), .KERNEL_DIM(3), .ROW_SIZE(5), .COL_SIZE(5), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .s(ifb.slave));
  // cnt is the in-frame index of the last accepted pixel when a window is consumed
  always @(negedge clk) begin
    if (rst) cnt = 0;
    else begin
      if (ifa.valid && ifa.out_ready) qa.push_back('{ifa.window, cnt, mxa});
      if (ifb.valid && ifb.out_ready) qb.push_back('{ifb.window, cnt, mxb});
      if (ifa.frame_done) fd_a++;
      if (ifb.frame_done) fd_b++;
      if (ifa.in_valid && ifa.in_ready) cnt = cnt == 25 ? 1 : cnt + 1;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  function automatic win_t mkwin(input int c);
    win_t w;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) w[r][k] = 8'(c + (r - 1) * 5 + (k - 1));
    return w;
  endfunction
  task automatic send(input int p);
    int n = 0;
    vld = 1'b1;
    pix = 8'(p);
    #1;
    while (!ifa.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
  endtask
  task automatic stream(input int a, input int b);
    for (int p = a; p <= b; p++) send(p);
  endtask
  task automatic verify(input string tag, input int ba, input int bb, input int nf);
    chk({tag, " count_a"}, qa.size() - ba, 9 * nf);
    chk({tag, " count_b"}, qb.size() - bb, 4 * nf);
    for (int i = 0; i < 9 * nf && ba + i < qa.size(); i++) begin
      chk($sformatf("%s a%0d win", tag, i), qa[ba+i].w, mkwin(t1[i%9].centre));
      chk($sformatf("%s a%0d acc", tag, i), qa[ba+i].acc, t1[i%9].acc);
`ifdef WINDOW_MAX_EN
      chk($sformatf("%s a%0d max", tag, i), qa[ba+i].mx, t1[i%9].mx);
`endif
    end
    for (int i = 0; i < 4 * nf && bb + i < qb.size(); i++) begin
      chk($sformatf("%s b%0d win", tag, i), qb[bb+i].w, mkwin(t2[i%4].centre));
      chk($sformatf("%s b%0d acc", tag, i), qb[bb+i].acc, t2[i%4].acc);
`ifdef WINDOW_MAX_EN
      chk($sformatf("%s b%0d max", tag, i), qb[bb+i].mx, t2[i%4].mx);
`endif
    end
  endtask
  initial begin
    int ba, bb, fa, fb;
    t1 = '{'{7, 13, 13}, '{8, 14, 14}, '{9, 15, 15}, '{12, 18, 18}, '{13, 19, 19},
           '{14, 20, 20}, '{17, 23, 23}, '{18, 24, 24}, '{19, 25, 25}};
    t2 = '{'{7, 13, 13}, '{9, 15, 15}, '{17, 23, 23}, '{19, 25, 25}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid_a", ifa.valid, 0);
    chk("rst valid_b", ifb.valid, 0);
    chk("rst fd_a", ifa.frame_done, 0);
    chk("rst win_a", ifa.window, 0);
    chk("rst win_b", ifb.window, 0);
    chk("rst max_a", mxa, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst in_ready_a", ifa.in_ready, 1);
    chk("post-rst in_ready_b", ifb.in_ready, 1);
    ba = qa.size(); bb = qb.size(); fa = fd_a; fb = fd_b;
    stream(1, 25);
    vld = 1'b0;
    chk("fd pulse", ifa.frame_done, 1);
    @(posedge clk); #1;
    chk("fd one-cycle", ifa.frame_done, 0);
    repeat (3) @(posedge clk);
    #1;
    verify("ramp", ba, bb, 1);
    chk("ramp fd_a", fd_a - fa, 1);
    chk("ramp fd_b", fd_b - fb, 1);
    ba = qa.size(); bb = qb.size();
    stream(1, 13);
    or_a = 1'b0;
    pix = 8'd14;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d in_ready", k), ifa.in_ready, 0);
      chk($sformatf("stall%0d valid", k), ifa.valid, 1);
      chk($sformatf("stall%0d win", k), ifa.window, mkwin(7));
      @(posedge clk); #1;
    end
    or_a = 1'b1;
    stream(14, 25);
    vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    verify("stall", ba, bb, 1);
    stream(1, 10);
    vld = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst valid", ifa.valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst in_ready", ifa.in_ready, 1);
    chk("midrst win", ifa.window, 0);
    ba = qa.size(); bb = qb.size(); fa = fd_a;
    stream(1, 25);
    vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    verify("midrst", ba, bb, 1);
    chk("midrst fd_a", fd_a - fa, 1);
    ba = qa.size(); bb = qb.size(); fa = fd_a;
    stream(1, 25);
    stream(1, 25);
    vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    verify("b2b", ba, bb, 2);
    chk("b2b fd_a", fd_a - fa, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
